// File: rtl/id_pkg.sv
// id_pkg: shared definitions for the RV32I decode stage.
//   - RV32I major opcode constants used by decode and hazard logic
//   - imm_type_e: immediate format selected by the opcode
//   - id_ex_t: decoded control/index payload held in the ID/EX register
//   - imm_type_of(): opcode -> immediate format mapping
package id_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    // Width-independent part of the ID/EX payload; the XLEN-wide
    // fields (pc, operands, immediate) live beside it in the top.
    typedef struct packed {
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic       is_load;
    } id_ex_t;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: t = IMM_I;
            OP_STORE:                 t = IMM_S;
            OP_BRANCH:                t = IMM_B;
            OP_LUI, OP_AUIPC:         t = IMM_U;
            OP_JAL:                   t = IMM_J;
            default:                  t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// id_regfile: REG_NUM x XLEN architectural register file.
//   clk, rst         clock, asynchronous active-high reset (clears all entries)
//   we/waddr/wdata   synchronous write port from writeback
//   raddr1/rdata1    combinational read port 1
//   raddr2/rdata2    combinational read port 2
// x0 and any index >= REG_NUM read as zero and ignore writes. A read of the
// register being written in the same cycle returns the write data.
module id_regfile #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    localparam int REG_AW = $clog2(REG_NUM);

    logic [XLEN-1:0] regs_q [REG_NUM];
    logic [XLEN-1:0] regs_d [REG_NUM];

    // An index is in range when the bits above REG_AW are all zero.
    logic w_in;
    logic r1_in;
    logic r2_in;

    if (REG_AW < 5) begin : g_partial
        assign w_in  = (waddr[4:REG_AW]  == '0);
        assign r1_in = (raddr1[4:REG_AW] == '0);
        assign r2_in = (raddr2[4:REG_AW] == '0);
    end else begin : g_full
        assign w_in  = 1'b1;
        assign r1_in = 1'b1;
        assign r2_in = 1'b1;
    end

    logic w_en;
    assign w_en = we && (waddr != '0) && w_in;

    always_comb begin
        regs_d = regs_q;
        if (w_en) begin
            regs_d[waddr[REG_AW-1:0]] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Write-through: the same-cycle write wins over the stored value.
    assign rdata1 = ((raddr1 == '0) || !r1_in) ? '0 :
                    (we && (waddr == raddr1))   ? wdata :
                    regs_q[raddr1[REG_AW-1:0]];
    assign rdata2 = ((raddr2 == '0) || !r2_in) ? '0 :
                    (we && (waddr == raddr2))   ? wdata :
                    regs_q[raddr2[REG_AW-1:0]];

endmodule

// File: rtl/id_decode_pipe.sv
// id_decode_pipe: RV32I decode stage with integrated ID/EX register.
//   if_valid/if_instr/if_pc/id_ready  instruction input from IF/ID
//   flush                             redirect from EXE, kills ID and ID/EX
//   wb_we/wb_rd_addr/wb_rd_data       register-file write from WB
//   ex_ready/ex_valid/ex_*            registered decoded instruction to EXE
//   hazard_stall                      combinational load-use stall
// Optional macro ID_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt,
// saturating 32-bit counts of stall cycles and flush cycles.
//
// Handshake: a transfer happens on a clk edge when valid and ready are both
// 1 on that side. ID/EX may load when it is empty or EXE takes its contents
// (advance). IF/ID must hold its instruction whenever id_ready is 0; a load-
// use hazard sends a bubble downstream instead of the instruction.
module id_decode_pipe
    import id_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            id_ready,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_rd_data,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [4:0]      ex_rs1_addr,
    output logic [4:0]      ex_rs2_addr,
    output logic [4:0]      ex_rd_addr,
    output logic [XLEN-1:0] ex_imm,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic [6:0]      ex_funct7,
    output logic            ex_is_load,
    output logic            hazard_stall
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    // ---------------- field extraction ----------------
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign funct7 = if_instr[31:25];

    // ---------------- register file ----------------
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    id_regfile #(
        .XLEN    (XLEN),
        .REG_NUM (REG_NUM)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_rd_addr),
        .wdata  (wb_rd_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // ---------------- immediate generation ----------------
    imm_type_e       imm_type;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;

    always_comb begin
        imm_type = imm_type_of(opcode);
        imm32    = '0;
        case (imm_type)
            IMM_I:   imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            IMM_S:   imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            IMM_B:   imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                              if_instr[30:25], if_instr[11:8], 1'b0};
            IMM_U:   imm32 = {if_instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                              if_instr[20], if_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Widen to XLEN by replicating bit 31 (XLEN >= 32 for RV32).
        imm = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
    end

    // ---------------- hazard and handshake ----------------
    id_ex_t          ex_q;
    id_ex_t          ex_d;
    logic            ex_valid_q;
    logic            ex_valid_d;
    logic [XLEN-1:0] ex_pc_q;
    logic [XLEN-1:0] ex_pc_d;
    logic [XLEN-1:0] ex_rs1_data_q;
    logic [XLEN-1:0] ex_rs1_data_d;
    logic [XLEN-1:0] ex_rs2_data_q;
    logic [XLEN-1:0] ex_rs2_data_d;
    logic [XLEN-1:0] ex_imm_q;
    logic [XLEN-1:0] ex_imm_d;

    logic rs1_used;
    logic rs2_used;
    logic advance;

    assign rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    assign rs2_used = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    assign hazard_stall = if_valid && ex_valid_q && ex_q.is_load && (ex_q.rd_addr != '0) &&
                          ((rs1_used && (rs1 == ex_q.rd_addr)) ||
                           (rs2_used && (rs2 == ex_q.rd_addr)));

    assign advance  = !ex_valid_q || ex_ready;
    assign id_ready = advance && !hazard_stall && !flush;

    // ---------------- ID/EX next state ----------------
    always_comb begin
        ex_valid_d    = ex_valid_q;
        ex_d          = ex_q;
        ex_pc_d       = ex_pc_q;
        ex_rs1_data_d = ex_rs1_data_q;
        ex_rs2_data_d = ex_rs2_data_q;
        ex_imm_d      = ex_imm_q;

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (advance) begin
            if (hazard_stall) begin
                // Bubble: only valid is cleared, payload is don't-care.
                ex_valid_d = 1'b0;
            end else begin
                ex_valid_d = if_valid;
                if (if_valid) begin
                    ex_d.rs1_addr = rs1;
                    ex_d.rs2_addr = rs2;
                    ex_d.rd_addr  = rd;
                    ex_d.opcode   = opcode;
                    ex_d.funct3   = funct3;
                    ex_d.funct7   = funct7;
                    ex_d.is_load  = (opcode == OP_LOAD);
                    ex_pc_d       = if_pc;
                    ex_rs1_data_d = rs1_data;
                    ex_rs2_data_d = rs2_data;
                    ex_imm_d      = imm;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_q          <= '0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
        end else begin
            ex_valid_q    <= ex_valid_d;
            ex_q          <= ex_d;
            ex_pc_q       <= ex_pc_d;
            ex_rs1_data_q <= ex_rs1_data_d;
            ex_rs2_data_q <= ex_rs2_data_d;
            ex_imm_q      <= ex_imm_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_rs1_data = ex_rs1_data_q;
    assign ex_rs2_data = ex_rs2_data_q;
    assign ex_rs1_addr = ex_q.rs1_addr;
    assign ex_rs2_addr = ex_q.rs2_addr;
    assign ex_rd_addr  = ex_q.rd_addr;
    assign ex_imm      = ex_imm_q;
    assign ex_opcode   = ex_q.opcode;
    assign ex_funct3   = ex_q.funct3;
    assign ex_funct7   = ex_q.funct7;
    assign ex_is_load  = ex_q.is_load;

`ifdef ID_PERF_CNT_EN
    // ---------------- performance counters ----------------
    logic [31:0] perf_stall_cnt_q;
    logic [31:0] perf_stall_cnt_d;
    logic [31:0] perf_flush_cnt_q;
    logic [31:0] perf_flush_cnt_d;

    always_comb begin
        perf_stall_cnt_d = perf_stall_cnt_q;
        perf_flush_cnt_d = perf_flush_cnt_q;
        if (hazard_stall && (perf_stall_cnt_q != 32'hFFFF_FFFF)) begin
            perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
        end
        if (flush && (perf_flush_cnt_q != 32'hFFFF_FFFF)) begin
            perf_flush_cnt_d = perf_flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt_q <= '0;
            perf_flush_cnt_q <= '0;
        end else begin
            perf_stall_cnt_q <= perf_stall_cnt_d;
            perf_flush_cnt_q <= perf_flush_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_stall_cnt_q;
    assign perf_flush_cnt = perf_flush_cnt_q;
`endif

endmodule
